// File: rtl/line_mem_ctrl_pkg.sv
// Shared types and sizes for the line memory controller.
package line_mem_ctrl_pkg;

   localparam int LINE_WORDS = 8;
   localparam int WORD_BITS  = 32;
   localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Word k of a line sits at index k, i.e. bits [32k+31:32k].
   typedef logic [LINE_WORDS-1:0][WORD_BITS-1:0] line_t;

endpackage

// File: rtl/line_mem_ctrl.sv
// Line-to-word memory controller: moves one 8-word cache line between the
// L1 and a 1-cycle-latency word SRAM, one word per cycle.
module line_mem_ctrl
   import line_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 l1_mmu_req_read,
   input  logic                 l1_mmu_req_write,
   input  logic [31:0]          l1_mmu_req_addr,
   input  logic [LINE_BITS-1:0] l1_mmu_write_data,
   output logic                 mmu_l1_done,
   output logic [LINE_BITS-1:0] mmu_l1_read_data,
   output logic                 busy,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [WORD_BITS-1:0] mem_wdata,
   input  logic [WORD_BITS-1:0] mem_rdata
);

   localparam int LINE_W = ADDR_W - 3;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              drain_q, drain_d;   // READ: all 8 issued, last word in flight
   logic              both_q, both_d;     // write request also carried a read
   logic [LINE_W-1:0] line_q, line_d;
   line_t             wdata_q, wdata_d;
   line_t             rbuf_q, rbuf_d;     // read words collected during READ
   line_t             rdata_q, rdata_d;   // published only when a read completes
   logic              rvld_q, rvld_d;     // a read was issued last cycle
   logic [2:0]        rcnt_q, rcnt_d;     // word index of that read

   // Offset and high address bits do not take part; the line wraps.
   logic unused_addr;
   assign unused_addr = ^{l1_mmu_req_addr[31:ADDR_W+2], l1_mmu_req_addr[4:0]};

   // Memory strobes are gated by rst so nothing is written in the reset cycle.
   assign mem_en    = ((state_q == S_WRITE) || (state_q == S_READ && !drain_q)) && !rst;
   assign mem_we    = (state_q == S_WRITE) && !rst;
   assign mem_addr  = {line_q, cnt_q};
   assign mem_wdata = wdata_q[cnt_q];
   assign busy      = (state_q != S_IDLE);
   assign mmu_l1_done      = (state_q == S_DONE);
   assign mmu_l1_read_data = rdata_q;

   // Next-state logic: request latch, word sequencing and read-data capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      both_d  = both_q;
      line_d  = line_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      rvld_d  = (state_q == S_READ) && !drain_q;
      rcnt_d  = cnt_q;
      if (rvld_q) rbuf_d[rcnt_q] = mem_rdata;
      case (state_q)
         S_IDLE: begin
            if (l1_mmu_req_read || l1_mmu_req_write) begin
               line_d  = l1_mmu_req_addr[ADDR_W+1:5];
               wdata_d = l1_mmu_write_data;
               cnt_d   = 3'd0;
               drain_d = 1'b0;
               both_d  = l1_mmu_req_read && l1_mmu_req_write;
               state_d = l1_mmu_req_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (cnt_q == 3'd7) begin
               state_d = S_DONE;
               if (both_q) rdata_d = wdata_q;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_READ: begin
            if (drain_q) begin
               // rbuf_d already holds word 7 captured this cycle.
               state_d = S_DONE;
               rdata_d = rbuf_d;
            end else if (cnt_q == 3'd7) begin
               drain_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         drain_q <= 1'b0;
         both_q  <= 1'b0;
         line_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         rvld_q  <= 1'b0;
         rcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         both_q  <= both_d;
         line_q  <= line_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         rvld_q  <= rvld_d;
         rcnt_q  <= rcnt_d;
      end
   end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl: word SRAM model, transaction
// monitor and a line-level reference memory.
module tb_line_mem_ctrl;
   import line_mem_ctrl_pkg::*;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic          sys_clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_rd = 1'b0, req_wr = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [255:0]  wdata = '0;
   logic          done, busy, mem_en, mem_we;
   logic [255:0]  rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   line_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .sys_clk(sys_clk), .rst(rst),
      .l1_mmu_req_read(req_rd), .l1_mmu_req_write(req_wr),
      .l1_mmu_req_addr(req_addr), .l1_mmu_write_data(wdata),
      .mmu_l1_done(done), .mmu_l1_read_data(rdata), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural 1-cycle-latency SRAM.
   logic [31:0] line_mem_sram [DEPTH];
   always @(posedge sys_clk) begin
      if (mem_en) begin
         if (mem_we) line_mem_sram[mem_addr] <= mem_wdata;
         else        mem_rdata <= line_mem_sram[mem_addr];
      end
   end

   // Memory transaction monitor.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [31:0]       wd;
   } tx_t;
   tx_t txq[$];
   always begin
      @(negedge sys_clk);
      #1;
      if (mem_en === 1'b1) txq.push_back('{mem_addr, mem_we, mem_wdata});
   end

   // Reference: word memory contents and the expected published read line.
   logic [31:0]  ref_mem [DEPTH];
   logic [255:0] exp_rdata = '0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks the 8 memory transactions of one operation on a line.
   task automatic check_txs(input string tag, input logic [ADDR_W-4:0] line,
                            input logic wr, input logic [255:0] data, input int n);
      check({tag, " mem count"}, 256'(txq.size()), 256'(n));
      for (int k = 0; k < n; k++) begin
         if (k < txq.size()) begin
            logic [2:0] kk;
            logic [ADDR_W-1:0] ea;
            kk = k[2:0];
            ea = {line, kk};
            if (wr) check($sformatf("%s tx%0d", tag, k), {txq[k].addr, txq[k].we, txq[k].wd},
                          {ea, 1'b1, data[32*k +: 32]});
            else    check($sformatf("%s tx%0d", tag, k), {txq[k].addr, txq[k].we},
                          {ea, 1'b0});
         end
      end
   endtask

   task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] data, input logic midop, input string tag);
      int dcyc, ndone;
      logic [ADDR_W-4:0] line;
      logic [255:0] cur;
      line = addr[ADDR_W+1:5];
      @(negedge sys_clk);
      rst = 1'b0; req_rd = rd; req_wr = wr; req_addr = addr; wdata = data;
      txq.delete();
      dcyc = -1; ndone = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge sys_clk);
         if (midop && c == 2) begin
            req_rd = 1'b0; req_wr = 1'b0; req_addr = ~addr; wdata = ~data;
         end
         if (midop && c == 3) begin req_rd = rd; req_wr = wr; end
         if (done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = c;
            req_rd = 1'b0; req_wr = 1'b0;
         end
      end
      check({tag, " latency"}, 256'(dcyc), wr ? 256'd9 : 256'd10);
      check({tag, " done count"}, 256'(ndone), 256'd1);
      check({tag, " idle"}, 256'(busy), 256'd0);
      check_txs(tag, line, wr, data, 8);
      for (int k = 0; k < 8; k++) cur[32*k +: 32] = ref_mem[{line, 3'(k)}];
      if (wr) begin
         for (int k = 0; k < 8; k++) ref_mem[{line, 3'(k)}] = data[32*k +: 32];
         if (rd) exp_rdata = data;
      end else begin
         exp_rdata = cur;
      end
      check({tag, " read_data"}, rdata, exp_rdata);
   endtask

   initial begin
      logic [255:0] d;
      int dc, nd;
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] v;
         v = $urandom;
         line_mem_sram[i] = v;
         ref_mem[i] = v;
      end

      // Reset state.
      rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst busy", 256'(busy), 256'd0);
      check("rst done", 256'(done), 256'd0);
      check("rst mem_en/we", {mem_en, mem_we}, 256'd0);
      check("rst mem_addr", 256'(mem_addr), 256'd0);
      check("rst mem_wdata", 256'(mem_wdata), 256'd0);
      check("rst read_data", rdata, 256'd0);

      // Write then read line 0x100.
      for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'h1111_1111 * (k + 1);
      run_op(1'b0, 1'b1, 32'h100, d, 1'b0, "wr100");
      run_op(1'b1, 1'b0, 32'h100, '0, 1'b0, "rd100");
      check("rd100 data", rdata, d);
      // Offset ignored.
      run_op(1'b1, 1'b0, 32'h11F, '0, 1'b0, "rd11F");
      check("rd11F data", rdata, d);
      // Write-with-read.
      run_op(1'b1, 1'b1, 32'h200, {8{32'hA5A5_A5A5}}, 1'b0, "both200");
      // A write alone leaves read_data alone.
      run_op(1'b0, 1'b1, 32'h280, {8{32'h0F0F_0F0F}}, 1'b0, "wr280");
      check("wr280 hold", rdata, {8{32'hA5A5_A5A5}});
      // Mid-operation changes ignored.
      run_op(1'b1, 1'b0, 32'h100, '0, 1'b1, "midop");
      check("midop data", rdata, d);
      // Address wrap.
      run_op(1'b0, 1'b1, 32'hFFFF_FFE0, {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom}, 1'b0, "wrwrap");
      run_op(1'b1, 1'b0, 32'h0000_FFE0, '0, 1'b0, "rdwrap");

      // Reset during the cnt=4 write cycle.
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge sys_clk);
      req_wr = 1'b1; req_addr = 32'h300; wdata = d;
      txq.delete();
      repeat (5) @(negedge sys_clk);
      rst = 1'b1; req_wr = 1'b0;
      nd = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge sys_clk);
         if (c == 2) rst = 1'b0;
         if (done === 1'b1) nd++;
      end
      check("abort done", 256'(nd), 256'd0);
      check("abort busy", 256'(busy), 256'd0);
      check_txs("abort", 11'h300 >> 5, 1'b1, d, 4);
      for (int k = 0; k < 8; k++) begin
         if (k < 4) ref_mem[{11'h18, 3'(k)}] = d[32*k +: 32];
         check($sformatf("abort word%0d", k), 256'(line_mem_sram[{11'h18, 3'(k)}]),
               256'(ref_mem[{11'h18, 3'(k)}]));
      end
      exp_rdata = '0;
      check("abort read_data", rdata, exp_rdata);

      // Request held through reset release.
      @(negedge sys_clk);
      rst = 1'b1; req_rd = 1'b1; req_addr = 32'h300;
      repeat (2) @(negedge sys_clk);
      check("held in rst busy", 256'(busy), 256'd0);
      run_op(1'b1, 1'b0, 32'h300, '0, 1'b0, "rstrel");

      // Back-to-back: request held through the cycle after done.
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge sys_clk);
      req_wr = 1'b1; req_addr = 32'h400; wdata = d;
      dc = -1;
      for (int c = 1; c <= 14 && dc < 0; c++) begin
         @(negedge sys_clk);
         if (done === 1'b1) dc = c;
      end
      check("b2b first done", 256'(dc), 256'd9);
      @(negedge sys_clk);
      @(negedge sys_clk);
      req_wr = 1'b0;
      check("b2b busy", 256'(busy), 256'd1);
      dc = -1;
      for (int c = 12; c <= 26 && dc < 0; c++) begin
         @(negedge sys_clk);
         if (done === 1'b1) dc = c;
      end
      check("b2b second done", 256'(dc), 256'd19);
      for (int k = 0; k < 8; k++) ref_mem[{11'h20, 3'(k)}] = d[32*k +: 32];
      repeat (2) @(negedge sys_clk);

      // Randomized operations against the reference memory.
      for (int i = 0; i < 16; i++) begin
         int sel;
         logic [31:0] a;
         sel = $urandom_range(0, 2);
         a = (i % 2 == 0) ? $urandom : {$urandom_range(0, 7), 5'($urandom)} + 32'h100;
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run_op(sel != 1, sel != 0, a, d, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
